// File: rtl/sequential_pkg.sv
// Shared definitions for the serial link: transmitter state encoding,
// frame bit levels and a width helper for bit-period dividers.
package sequential_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Divider counter width: enough bits to count 0..div-1, never narrower than one bit.
   function automatic int div_cnt_width(input int div);
      return (div <= 1) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/serial_tx_piso_bit_timer.sv
// Bit-period divider: counts 0..DIV-1 and flags the last cycle of each bit.
// Held at zero while clear is asserted so every frame starts on a fresh period.
module bit_timer
   import sequential_pkg::*;
#(
   parameter int DIV = 4
)
(
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int               CNT_W = div_cnt_width(DIV);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = (cnt_q == LAST);

   // Next count: clear wins, otherwise wrap on the last cycle of the period.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Divider counter register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/serial_tx_piso.sv
// Parallel-in serial-out transmitter. Frames one word as a start bit,
// DATA_W data bits LSB-first and a stop bit, each held DIV clock cycles.
// tx is registered from the next-state values so it changes on the same
// edge as the state and never glitches.
module serial_tx_piso
   import sequential_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DIV    = 4
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              load,
   output logic              ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int                BCNT_W   = $clog2(DATA_W + 1);
   localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

   tx_state_t         state_q;
   tx_state_t         state_d;
   logic [DATA_W-1:0] shreg_q;
   logic [DATA_W-1:0] shreg_d;
   logic [BCNT_W-1:0] bitcnt_q;
   logic [BCNT_W-1:0] bitcnt_d;
   logic              tx_q;
   logic              tx_d;
   logic              done_q;
   logic              done_d;
   logic              timer_clear;
   logic              tick;

   bit_timer #(
      .DIV (DIV)
   ) u_bit_timer (
      .clock (clock),
      .reset (reset),
      .clear (timer_clear),
      .tick  (tick)
   );

   // Frame sequencing, shift register and bit counter updates, next tx level.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bitcnt_d    = bitcnt_q;
      done_d      = 1'b0;
      timer_clear = 1'b0;

      case (state_q)
         IDLE: begin
            timer_clear = 1'b1;
            if (load) begin
               shreg_d  = data_in;
               bitcnt_d = '0;
               state_d  = START;
            end else begin
               state_d  = IDLE;
            end
         end
         START: begin
            if (tick) begin
               bitcnt_d = '0;
               state_d  = DATA;
            end else begin
               state_d  = START;
            end
         end
         DATA: begin
            if (tick) begin
               shreg_d  = shreg_q >> 1'b1;
               bitcnt_d = bitcnt_q + BCNT_W'(1);
               if (bitcnt_q == LAST_BIT) begin
                  state_d = STOP;
               end else begin
                  state_d = DATA;
               end
            end else begin
               state_d = DATA;
            end
         end
         STOP: begin
            if (tick) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            timer_clear = 1'b1;
            state_d     = IDLE;
         end
      endcase

      case (state_d)
         IDLE:    tx_d = STOP_BIT;
         START:   tx_d = START_BIT;
         DATA:    tx_d = shreg_d[0];
         STOP:    tx_d = STOP_BIT;
         default: tx_d = STOP_BIT;
      endcase
   end

   // State, datapath and output registers; reset forces an idle line at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         tx_q     <= STOP_BIT;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         tx_q     <= tx_d;
         done_q   <= done_d;
      end
   end

   assign ready = (state_q == IDLE);
   assign busy  = (state_q != IDLE);
   assign tx    = tx_q;
   assign done  = done_q;

endmodule

// File: tb/tb_serial_tx_piso.sv
// Self-checking bench for serial_tx_piso: an 8-bit/DIV=4 instance and a
// 4-bit/DIV=1 instance. Expected tx levels are queued per cycle when a
// word is loaded and popped as the line is sampled on falling edges.
module tb_serial_tx_piso;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       load = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       ready, tx, busy, done;
   logic       load1 = 1'b0;
   logic [3:0] data_in1 = 4'h0;
   logic       ready1, tx1, busy1, done1;

   int   checks = 0;
   int   failures = 0;
   logic exp_q[$];

   always #5 clock = ~clock;

   serial_tx_piso #(.DATA_W(8), .DIV(4)) dut (
      .clock(clock), .reset(reset), .data_in(data_in), .load(load),
      .ready(ready), .tx(tx), .busy(busy), .done(done));

   serial_tx_piso #(.DATA_W(4), .DIV(1)) dut1 (
      .clock(clock), .reset(reset), .data_in(data_in1), .load(load1),
      .ready(ready1), .tx(tx1), .busy(busy1), .done(done1));

   // Queue the per-cycle line levels of one frame.
   task automatic push_frame(input logic [7:0] d, input int w, input int div);
      for (int k = 0; k < div; k++) exp_q.push_back(1'b0);
      for (int b = 0; b < w; b++)
         for (int k = 0; k < div; k++) exp_q.push_back(d[b]);
      for (int k = 0; k < div; k++) exp_q.push_back(1'b1);
   endtask

   // Next expected level, X when nothing is queued so the compare fails.
   function automatic logic pop_exp();
      if (exp_q.size() == 0) return 1'bx;
      return exp_q.pop_front();
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      checks++;
      if ({tx, ready, busy, done} !== 4'b1100) begin
         failures++;
         $display("FAIL reset_state tx/ready/busy/done got %b want 1100", {tx, ready, busy, done});
      end
      checks++;
      if ({tx1, ready1, busy1, done1} !== 4'b1100) begin
         failures++;
         $display("FAIL reset_state_div1 got %b want 1100", {tx1, ready1, busy1, done1});
      end
      reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         checks++;
         if ({tx, ready, busy, done} !== 4'b1100) begin
            failures++;
            $display("FAIL idle cycle %0d got %b want 1100", c, {tx, ready, busy, done});
         end
      end
   endtask

   task automatic test_single_frame(input logic [7:0] d);
      logic e;
      @(negedge clock);
      data_in = d;
      load = 1'b1;
      push_frame(d, 8, 4);
      for (int c = 1; c <= 42; c++) begin
         @(negedge clock);
         load = 1'b0;
         data_in = ~d;
         if (c <= 40) begin
            e = pop_exp();
            checks++;
            if (tx !== e) begin
               failures++;
               $display("FAIL frame_%h_tx cycle %0d got %b want %b", d, c, tx, e);
            end
            checks++;
            if ({ready, busy, done} !== 3'b010) begin
               failures++;
               $display("FAIL frame_%h_flags cycle %0d got %b want 010", d, c, {ready, busy, done});
            end
         end else if (c == 41) begin
            checks++;
            if ({tx, ready, busy, done} !== 4'b1101) begin
               failures++;
               $display("FAIL frame_%h_done got %b want 1101", d, {tx, ready, busy, done});
            end
         end else begin
            checks++;
            if ({tx, ready, done} !== 3'b110) begin
               failures++;
               $display("FAIL frame_%h_after got %b want 110", d, {tx, ready, done});
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic e;
      int   done_at[$];
      @(negedge clock);
      data_in = 8'h0F;
      load = 1'b1;
      push_frame(8'h0F, 8, 4);
      for (int c = 1; c <= 83; c++) begin
         @(negedge clock);
         load = 1'b0;
         if (done === 1'b1) done_at.push_back(c);
         if (c == 41) begin
            checks++;
            if ({tx, ready, done} !== 3'b111) begin
               failures++;
               $display("FAIL b2b_done_cycle got %b want 111", {tx, ready, done});
            end
            data_in = 8'hF0;
            load = 1'b1;
            push_frame(8'hF0, 8, 4);
         end else if (c <= 81) begin
            e = pop_exp();
            checks++;
            if (tx !== e) begin
               failures++;
               $display("FAIL b2b_tx cycle %0d got %b want %b", c, tx, e);
            end
         end
      end
      checks++;
      if (done_at.size() != 2) begin
         failures++;
         $display("FAIL b2b_done_count got %0d want 2", done_at.size());
      end else begin
         checks++;
         if (done_at[1] - done_at[0] != 41) begin
            failures++;
            $display("FAIL b2b_done_spacing got %0d want 41", done_at[1] - done_at[0]);
         end
      end
   endtask

   task automatic test_ignored_load();
      logic e;
      int   n_done = 0;
      @(negedge clock);
      data_in = 8'h3C;
      load = 1'b1;
      push_frame(8'h3C, 8, 4);
      for (int c = 1; c <= 45; c++) begin
         @(negedge clock);
         if (done === 1'b1) n_done++;
         if (c <= 40) begin
            e = pop_exp();
            checks++;
            if (tx !== e) begin
               failures++;
               $display("FAIL ignored_tx cycle %0d got %b want %b", c, tx, e);
            end
         end
         load = (c == 10 || c == 25) ? 1'b1 : 1'b0;
         data_in = (c == 10 || c == 25) ? 8'hFF : 8'h3C;
      end
      checks++;
      if (n_done != 1) begin
         failures++;
         $display("FAIL ignored_done_count got %0d want 1", n_done);
      end
   endtask

   task automatic test_reset_mid_frame();
      @(negedge clock);
      data_in = 8'h55;
      load = 1'b1;
      push_frame(8'h55, 8, 4);
      for (int c = 1; c <= 15; c++) begin
         @(negedge clock);
         load = 1'b0;
      end
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL midreset_pre_busy got %b want 1", busy);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({tx, busy, ready} !== 3'b101) begin
         failures++;
         $display("FAIL midreset_async tx/busy/ready got %b want 101", {tx, busy, ready});
      end
      exp_q.delete();
      @(negedge clock);
      reset = 1'b0;
      for (int c = 0; c < 45; c++) begin
         @(negedge clock);
         checks++;
         if ({tx, ready, done} !== 3'b110) begin
            failures++;
            $display("FAIL midreset_after cycle %0d got %b want 110", c, {tx, ready, done});
         end
      end
      test_single_frame(8'h81);
   endtask

   task automatic test_div1();
      logic e;
      @(negedge clock);
      data_in1 = 4'h9;
      load1 = 1'b1;
      push_frame({4'h0, 4'h9}, 4, 1);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clock);
         load1 = 1'b0;
         data_in1 = 4'h6;
         if (c <= 6) begin
            e = pop_exp();
            checks++;
            if ({tx1, ready1, done1} !== {e, 2'b00}) begin
               failures++;
               $display("FAIL div1 cycle %0d tx/ready/done got %b want %b", c, {tx1, ready1, done1}, {e, 2'b00});
            end
         end else if (c == 7) begin
            checks++;
            if ({tx1, ready1, done1} !== 3'b111) begin
               failures++;
               $display("FAIL div1_done got %b want 111", {tx1, ready1, done1});
            end
         end else begin
            checks++;
            if (done1 !== 1'b0) begin
               failures++;
               $display("FAIL div1_done_width got %b want 0", done1);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame(8'hA5);
      test_back_to_back();
      test_ignored_load();
      test_reset_mid_frame();
      test_div1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_tx_piso.md
Name: serial_tx_piso

Overview:
Parallel-in serial-out transmitter; the sending end of the team's serial shift-register receiver built from edge-triggered D flip-flops. It accepts one DATA_W-bit word through a ready/load handshake and frames it onto a single line. Each frame is one start bit (0), the data bits LSB-first, and one stop bit (1). Every bit is held DIV clock cycles. It sits between a parallel data source and the serial link.

Parameters:
DATA_W, 8, data word width in bits (at least 1)
DIV, 4, clock cycles per serial bit (at least 1; DIV=1 must work)

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  DATA_W  word to transmit; sampled only on an accepted load
load  input  1  request to send data_in
ready  output  1  block can accept load this cycle
tx  output  1  serial line; idles at 1
busy  output  1  frame in progress (START, DATA or STOP state)
done  output  1  one-cycle pulse: the frame just completed

Behaviour:
- Reset is asynchronous and active-high, and the single clock is `clock`. While reset=1: state=IDLE, tx=1, ready=1, busy=0, done=0, and the shift register and both counters are 0. tx goes to 1 immediately when reset asserts mid-frame, without waiting for a clock edge. The partial frame is abandoned and never resumed.
- States: IDLE, START, DATA, STOP.
- IDLE: tx=1, ready=1, busy=0.
  - load=1 at a rising edge accepts the word: data_in is captured into the shift register, the divider is cleared, and the state becomes START.
  - load=0 keeps the state in IDLE.
- START: tx=0 for DIV cycles, then go to DATA with the bit counter at 0.
- DATA: tx = shift register bit 0.
  - After every DIV cycles, shift right by one and increment the bit counter.
  - After DATA_W bits, go to STOP.
- STOP: tx=1 for DIV cycles, then go to IDLE with done=1 for that first IDLE cycle.
- ready equals (state==IDLE). busy equals (state != IDLE). done is registered and high for exactly one cycle per completed frame.
- Latency: tx falls on the first rising edge after acceptance. A frame lasts exactly (DATA_W+2)*DIV cycles. done rises (DATA_W+2)*DIV cycles after the accepting edge.
- Back-to-back: load=1 during the done cycle is accepted (ready=1 there). The next start bit follows the previous stop bit with no idle gap beyond that one cycle.
- load while busy=1 is ignored. data_in changes while busy do not affect the frame in flight.
- Divider width is max(1, clog2(DIV)); it counts 0..DIV-1 and wraps to 0 on each bit boundary. Bit counter width is clog2(DATA_W+1).
- Unreachable state encodings recover to IDLE on the next edge with tx=1.

Decomposition:
- Shared package sequential_pkg holds the state enum tx_state_t (IDLE, START, DATA, STOP) and the frame constants START_BIT=0 and STOP_BIT=1. The receiver reuses both.
- One sub-module, bit_timer: parameter DIV, inputs clock, reset, clear, output tick. tick pulses on the last cycle of each bit period. The FSM, shift register and bit counter stay in serial_tx_piso.

Test Plan:
- Reset then idle (DATA_W=8, DIV=4): after reset, hold load=0 for 20 cycles -> tx=1, ready=1, busy=0, done=0 throughout.
- Single frame: load=1 with data_in=8'hA5 for one cycle -> tx sequence 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles. done pulses once, 40 cycles after the accepting edge. ready=0 for those 40 cycles.
- Back-to-back: send 8'h0F, then assert load with 8'hF0 in the done cycle -> the second start bit immediately follows the first stop bit. Second frame data bits on tx: 0,0,0,0,1,1,1,1. Two done pulses, 41 cycles apart.
- Ignored load: during the 8'h3C frame, pulse load with data_in=8'hFF at cycles 10 and 25 -> the transmitted bits still equal 8'h3C and only one done pulse occurs.
- Reset mid-frame: assert reset asynchronously (between clock edges) in the DATA state of an 8'h55 frame -> tx=1 and busy=0 before the next clock edge. After release, no done pulse and ready=1. A new load of 8'h81 then sends a clean frame.
- DIV=1, DATA_W=4: send 4'h9 -> tx = 0,1,0,0,1,1 on consecutive cycles. done follows 6 cycles after acceptance.
